// File: rtl/adc_capture.sv
// ADC sampler with level/edge trigger, sample decimation and a DEPTH-deep capture buffer (1-cycle registered readout).
// Define ADC_AUTO_TRIG_EN to force a trigger after AUTO_TO qualified samples spent waiting in WAIT_TRIG.
module adc_capture #(
  parameter int DEPTH   = 256,
  parameter int CLK_DIV = 4,
  parameter int AUTO_TO = 65535
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic [7:0]               ad_data_in,
  output logic                     ad_clk,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [1:0]               trig_level,
  input  logic                     trig_edge,
  input  logic [1:0]               decim,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     auto_trig
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT, S_CAPT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic          ad_clk_q, strobe;
  logic [7:0]    smp_q;
  logic          smp_vld_q;
  logic [2:0]    dec_q, dec_d, dec_mask;
  logic [1:0]    lvl_q, lvl_d, dsel_q, dsel_d;
  logic          fall_q, fall_d;
  logic [7:0]    prev_q, prev_d, lvl_val;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          qual, hit, timeout, we;
  logic [7:0]    rd_q;
  logic [7:0]    mem [DEPTH];

  // Divider: ad_clk is registered so it is low during reset yet tracks the count afterwards.
  assign strobe = (div_q == CW'(CLK_DIV - 1));
  assign div_d  = strobe ? '0 : div_q + CW'(1);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      ad_clk_q  <= 1'b0;
      smp_q     <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      ad_clk_q  <= (div_d < CW'(CLK_DIV / 2));
      smp_vld_q <= strobe;
      if (strobe) smp_q <= ad_data_in;
    end
  end

  always_comb begin
    dec_mask = 3'd0;
    case (dsel_q)
      2'd1:    dec_mask = 3'd1;
      2'd2:    dec_mask = 3'd3;
      2'd3:    dec_mask = 3'd7;
      default: dec_mask = 3'd0;
    endcase
  end

  assign qual    = smp_vld_q && (dec_q == 3'd0);
  assign lvl_val = {lvl_q, 6'd0};
  assign hit     = fall_q ? (prev_q >= lvl_val && smp_q < lvl_val)
                          : (prev_q < lvl_val && smp_q >= lvl_val);

`ifdef ADC_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TO + 1);
  logic [TW-1:0] to_q, to_d;
  logic          auto_q, auto_d;
  assign timeout   = (to_q == TW'(AUTO_TO - 1));
  assign auto_trig = auto_q;
`else
  logic unused_auto_to;
  assign unused_auto_to = (AUTO_TO != 0);
  assign timeout   = 1'b0;
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    fall_d  = fall_q;
    dsel_d  = dsel_q;
    prev_d  = prev_q;
    waddr_d = waddr_q;
    we      = 1'b0;
    dec_d   = smp_vld_q ? ((dec_q + 3'd1) & dec_mask) : dec_q;
`ifdef ADC_AUTO_TRIG_EN
    to_d    = to_q;
    auto_d  = auto_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
`ifdef ADC_AUTO_TRIG_EN
      auto_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d = S_ARMED;
            lvl_d   = trig_level;
            fall_d  = trig_edge;
            dsel_d  = decim;
            dec_d   = 3'd0;
            waddr_d = '0;
`ifdef ADC_AUTO_TRIG_EN
            auto_d  = 1'b0;
`endif
          end
        end
        S_ARMED: begin
          if (qual) begin
            prev_d = smp_q;
            if (lvl_q == 2'd0) begin
              we      = 1'b1;
              waddr_d = waddr_q + AW'(1);
              state_d = S_CAPT;
            end else begin
              state_d = S_WAIT;
`ifdef ADC_AUTO_TRIG_EN
              to_d    = '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (qual) begin
            prev_d = smp_q;
            if (hit || timeout) begin
              we      = 1'b1;
              waddr_d = waddr_q + AW'(1);
              state_d = S_CAPT;
            end
`ifdef ADC_AUTO_TRIG_EN
            to_d = to_q + TW'(1);
            if (timeout && !hit) auto_d = 1'b1;
`endif
          end
        end
        S_CAPT: begin
          // Last address written means the buffer is full: stop, never wrap.
          if (qual) begin
            we = 1'b1;
            if (waddr_q == AW'(DEPTH - 1)) state_d = S_DONE;
            else                           waddr_d = waddr_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      fall_q  <= 1'b0;
      dsel_q  <= '0;
      dec_q   <= '0;
      prev_q  <= '0;
      waddr_q <= '0;
`ifdef ADC_AUTO_TRIG_EN
      to_q    <= '0;
      auto_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      fall_q  <= fall_d;
      dsel_q  <= dsel_d;
      dec_q   <= dec_d;
      prev_q  <= prev_d;
      waddr_q <= waddr_d;
`ifdef ADC_AUTO_TRIG_EN
      to_q    <= to_d;
      auto_q  <= auto_d;
`endif
    end
  end

  // Buffer is deliberately left out of reset so it maps onto a plain RAM.
  always_ff @(posedge clk_50M) begin
    if (we) mem[waddr_q] <= smp_q;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= mem[rd_addr];
  end

  assign ad_clk  = ad_clk_q;
  assign rd_data = rd_q;
  assign busy    = (state_q == S_ARMED) || (state_q == S_WAIT) || (state_q == S_CAPT);
  assign done    = (state_q == S_DONE);
endmodule
